// File: rtl/ir_heart_rate_detector_if.sv
// Filtered IR sample stream into the heart-rate detector and its results out.
// The sample source or a testbench takes the master side; the detector takes slave.
interface ir_heart_rate_detector_if;
    logic        Filtered_Valid;
    logic [19:0] In_IR_Filtered;
    logic        Beat_Pulse;
    logic [7:0]  Heart_Rate;
    logic        HR_Valid;
    logic        Signal_Lost;

    modport master (
        output Filtered_Valid, In_IR_Filtered,
        input  Beat_Pulse, Heart_Rate, HR_Valid, Signal_Lost
    );

    modport slave (
        input  Filtered_Valid, In_IR_Filtered,
        output Beat_Pulse, Heart_Rate, HR_Valid, Signal_Lost
    );
endinterface

// File: rtl/ir_heart_rate_detector.sv
// Hysteresis peak detector with refractory window, beat interval counter
// and a 16-step restoring divider turning the interval into BPM.
module ir_heart_rate_detector #(
    parameter int          SAMPLE_RATE_HZ  = 500,
    parameter logic [19:0] HYST            = 20'd256,
    parameter int          REFRACT_SAMPLES = 150,
    parameter int          TIMEOUT_SAMPLES = 1500
) (
    input logic CLK_Filter,
    input logic rst_n,
    ir_heart_rate_detector_if.slave hr
);
    localparam int IW = $clog2(TIMEOUT_SAMPLES + 1);
    localparam logic [IW-1:0] TMO    = IW'(TIMEOUT_SAMPLES);
    localparam logic [IW-1:0] TMO_M1 = IW'(TIMEOUT_SAMPLES - 1);
    localparam logic [IW-1:0] REFR   = IW'(REFRACT_SAMPLES);
    localparam logic [IW-1:0] ONE    = IW'(1);
    localparam logic [15:0] DIVIDEND = 16'(60 * SAMPLE_RATE_HZ);

    typedef enum logic {SEEK_MIN, RISE} state_t;
    state_t state_q, state_d;

    logic          stb;
    logic [19:0]   smp;
    logic [19:0]   min_q, max_q, min_thr;
    logic [20:0]   min_sum;
    logic [IW-1:0] iv_q, iv_inc;
    logic          have_prev_q;
    logic          timeout, rise, peak, accept, start_div;

    logic          busy_q;
    logic [4:0]    cnt_q;
    logic [15:0]   rem_q, dvd_q, quo_q, dsr_q;
    logic [16:0]   rem_sh;
    logic          q_bit;
    logic [7:0]    bpm_sat;

    logic          beat_q, hr_valid_q, lost_q;
    logic [7:0]    rate_q;

    assign stb = hr.Filtered_Valid;
    assign smp = hr.In_IR_Filtered;

    always_comb begin
        min_sum   = {1'b0, min_q} + {1'b0, HYST};
        min_thr   = min_sum[20] ? 20'hFFFFF : min_sum[19:0];
        iv_inc    = (iv_q == TMO) ? TMO : iv_q + ONE;
        // Timeout fires only on the strobe that reaches the limit, not while saturated.
        timeout   = stb && (iv_q == TMO_M1);
        rise      = (state_q == SEEK_MIN) && (smp > min_thr);
        peak      = (state_q == RISE) &&
                    (({1'b0, smp} + {1'b0, HYST}) < {1'b0, max_q});
        accept    = stb && !timeout && peak &&
                    (!have_prev_q || iv_inc >= REFR);
        start_div = accept && have_prev_q && !busy_q;

        state_d = state_q;
        if (stb) begin
            if (timeout)   state_d = SEEK_MIN;
            else if (rise) state_d = RISE;
            else if (peak) state_d = SEEK_MIN;
        end

        rem_sh  = {rem_q, dvd_q[15]};
        q_bit   = rem_sh >= {1'b0, dsr_q};
        bpm_sat = (|quo_q[15:8]) ? 8'hFF : quo_q[7:0];
    end

    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) state_q <= SEEK_MIN;
        else        state_q <= state_d;
    end

    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            min_q       <= '1;
            max_q       <= '0;
            iv_q        <= '0;
            have_prev_q <= 1'b0;
            beat_q      <= 1'b0;
            lost_q      <= 1'b1;
        end else begin
            beat_q <= accept;
            if (stb) begin
                iv_q <= accept ? '0 : iv_inc;
                if (timeout) begin
                    min_q       <= smp;
                    have_prev_q <= 1'b0;
                    lost_q      <= 1'b1;
                end else begin
                    if (state_q == SEEK_MIN && smp < min_q) min_q <= smp;
                    if (rise) max_q <= smp;
                    if (state_q == RISE && smp > max_q) max_q <= smp;
                    if (peak) min_q <= smp;
                    if (accept) begin
                        have_prev_q <= 1'b1;
                        lost_q      <= 1'b0;
                    end
                end
            end
        end
    end

    // Divider runs every clock once started; 16 steps then one write-back clock.
    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            quo_q      <= '0;
            dsr_q      <= '0;
            rate_q     <= '0;
            hr_valid_q <= 1'b0;
        end else begin
            hr_valid_q <= 1'b0;
            if (timeout) begin
                busy_q <= 1'b0;
                rate_q <= '0;
            end else if (start_div) begin
                busy_q <= 1'b1;
                cnt_q  <= '0;
                rem_q  <= '0;
                dvd_q  <= DIVIDEND;
                quo_q  <= '0;
                dsr_q  <= 16'(iv_inc);
            end else if (busy_q) begin
                if (cnt_q == 5'd16) begin
                    busy_q     <= 1'b0;
                    rate_q     <= bpm_sat;
                    hr_valid_q <= 1'b1;
                end else begin
                    rem_q <= q_bit ? 16'(rem_sh - {1'b0, dsr_q}) : rem_sh[15:0];
                    dvd_q <= {dvd_q[14:0], 1'b0};
                    quo_q <= {quo_q[14:0], q_bit};
                    cnt_q <= cnt_q + 5'd1;
                end
            end
        end
    end

    assign hr.Beat_Pulse  = beat_q;
    assign hr.Heart_Rate  = rate_q;
    assign hr.HR_Valid    = hr_valid_q;
    assign hr.Signal_Lost = lost_q;
endmodule

// File: tb/tb_ir_heart_rate_detector.sv
// Bench for ir_heart_rate_detector: waveform scenarios against an
// event-level model of beats, BPM results and signal loss.
module tb_ir_heart_rate_detector;
    localparam int HYST = 256;
    localparam int REFR = 150;
    localparam int TMO  = 1500;
    localparam int DIVD = 30000;

    logic CLK_Filter = 1'b0;
    logic rst_n;
    ir_heart_rate_detector_if hif();

    ir_heart_rate_detector dut (
        .CLK_Filter (CLK_Filter),
        .rst_n      (rst_n),
        .hr         (hif)
    );

    always #5 CLK_Filter = ~CLK_Filter;

    int cyc = 0;
    always @(posedge CLK_Filter) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Events: time*512 + value, where value 256 marks a beat, else a BPM result.
    int obs_ev[$];
    int exp_ev[$];

    always @(negedge CLK_Filter) begin
        if (rst_n === 1'b1) begin
            if (hif.Beat_Pulse === 1'b1) obs_ev.push_back(cyc * 512 + 256);
            if (hif.HR_Valid === 1'b1)
                obs_ev.push_back(cyc * 512 + int'(hif.Heart_Rate));
        end
    end

    int m_mode, m_min, m_max, m_iv, m_prev, m_lost, m_hr;
    int m_busy_end, m_pushes;

    task automatic drop_from(input int t);
        int keep[$];
        foreach (exp_ev[i]) if (exp_ev[i] / 512 < t) keep.push_back(exp_ev[i]);
        exp_ev = keep;
    endtask

    task automatic model_reset();
        m_mode = 0; m_min = 'hFFFFF; m_max = 0; m_iv = 0; m_prev = 0;
        m_lost = 1; m_hr = 0; m_busy_end = -1;
        drop_from(cyc + 1);
    endtask

    // c is the index of the clock edge that samples this strobe.
    task automatic model_strobe(input int c, input int s);
        int iv, thr, bpm;
        bit pk;
        iv = (m_iv >= TMO) ? TMO : m_iv + 1;
        if (iv == TMO && m_iv != TMO) begin
            m_lost = 1; m_hr = 0; m_prev = 0; m_mode = 0; m_min = s;
            m_iv = iv; m_busy_end = -1;
            drop_from(c);
            return;
        end
        pk = 0;
        if (m_mode == 0) begin
            thr = (m_min + HYST > 'hFFFFF) ? 'hFFFFF : m_min + HYST;
            if (s > thr) begin m_mode = 1; m_max = s; end
            if (s < m_min) m_min = s;
        end else begin
            if (s > m_max) m_max = s;
            if (s + HYST < m_max) begin pk = 1; m_mode = 0; m_min = s; end
        end
        if (pk && (m_prev == 0 || iv >= REFR)) begin
            exp_ev.push_back(c * 512 + 256);
            m_lost = 0;
            if (m_prev != 0 && c > m_busy_end) begin
                bpm = DIVD / iv;
                if (bpm > 255) bpm = 255;
                exp_ev.push_back((c + 17) * 512 + bpm);
                m_hr = bpm; m_busy_end = c + 17; m_pushes++;
            end
            m_prev = 1; m_iv = 0;
        end else begin
            m_iv = iv;
        end
    endtask

    function automatic int first_diff(input int a[$], input int b[$]);
        int n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    function automatic string ev_at(input int q[$], input int i);
        if (i < 0 || i >= q.size()) return "none";
        if (q[i] % 512 == 256) return $sformatf("beat@%0d", q[i] / 512);
        return $sformatf("bpm%0d@%0d", q[i] % 512, q[i] / 512);
    endfunction

    function automatic int count_beats(input int q[$]);
        int n = 0;
        foreach (q[i]) if (q[i] % 512 == 256) n++;
        return n;
    endfunction

    function automatic bit has_bpm(input int q[$], input int v);
        foreach (q[i]) if (q[i] % 512 == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK_Filter); #1; end
    endtask

    task automatic send(input int s, input int gap);
        hif.Filtered_Valid = 1'b1;
        hif.In_IR_Filtered = 20'(s);
        model_strobe(cyc + 1, s);
        @(posedge CLK_Filter); #1;
        hif.Filtered_Valid = 1'b0;
        repeat (gap - 1) begin @(posedge CLK_Filter); #1; end
    endtask

    task automatic tri_wave(input int np, input int per, input int amp,
                            input int base, input int glo, input int ghi,
                            input int noise, input bit stop_bpm);
        int h, v, p0;
        h = per / 2;
        p0 = m_pushes;
        for (int p = 0; p < np; p++) begin
            for (int i = 0; i < per; i++) begin
                v = (i < h) ? base + amp * i / h : base + amp * (per - i) / h;
                if (noise > 0) v = v + int'($urandom_range(0, 2 * noise)) - noise;
                if (v < 0) v = 0;
                if (v > 'hFFFFF) v = 'hFFFFF;
                send(v, int'($urandom_range(glo, ghi)));
                if (stop_bpm && m_pushes != p0) return;
            end
        end
    endtask

    task automatic clear_ev();
        obs_ev.delete();
        exp_ev.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hif.Filtered_Valid = 1'b0;
        hif.In_IR_Filtered = '0;
        idle(3);
        tests++;
        if (hif.Beat_Pulse !== 1'b0) begin
            fails++; $display("FAIL reset Beat_Pulse: got %b want 0", hif.Beat_Pulse);
        end
        tests++;
        if (hif.HR_Valid !== 1'b0) begin
            fails++; $display("FAIL reset HR_Valid: got %b want 0", hif.HR_Valid);
        end
        tests++;
        if (hif.Heart_Rate !== 8'd0) begin
            fails++; $display("FAIL reset Heart_Rate: got %0d want 0", hif.Heart_Rate);
        end
        tests++;
        if (hif.Signal_Lost !== 1'b1) begin
            fails++; $display("FAIL reset Signal_Lost: got %b want 1", hif.Signal_Lost);
        end
        rst_n = 1'b1;
        model_reset();
        idle(2);
    endtask

    task automatic test_triangle_60();
        int d;
        clear_ev();
        tri_wave(4, 500, 4000, 0, 4, 4, 0, 1'b0);
        idle(30);
        obs_ev.sort(); exp_ev.sort();
        d = first_diff(obs_ev, exp_ev);
        tests++;
        if (d >= 0) begin
            fails++;
            $display("FAIL tri60 events: got %0d (%s) want %0d (%s)",
                     obs_ev.size(), ev_at(obs_ev, d), exp_ev.size(), ev_at(exp_ev, d));
        end
        tests++;
        if (count_beats(obs_ev) != 4) begin
            fails++; $display("FAIL tri60 beats: got %0d want 4", count_beats(obs_ev));
        end
        tests++;
        if (hif.Heart_Rate !== 8'd60) begin
            fails++; $display("FAIL tri60 Heart_Rate: got %0d want 60", hif.Heart_Rate);
        end
        tests++;
        if (hif.Signal_Lost !== 1'b0) begin
            fails++; $display("FAIL tri60 Signal_Lost: got %b want 0", hif.Signal_Lost);
        end
    endtask

    task automatic test_rate_change();
        int d;
        clear_ev();
        tri_wave(3, 250, 4000, 0, 1, 3, 0, 1'b0);
        tri_wave(3, 200, 4000, 0, 1, 3, 0, 1'b0);
        idle(30);
        obs_ev.sort(); exp_ev.sort();
        d = first_diff(obs_ev, exp_ev);
        tests++;
        if (d >= 0) begin
            fails++;
            $display("FAIL rate events: got %0d (%s) want %0d (%s)",
                     obs_ev.size(), ev_at(obs_ev, d), exp_ev.size(), ev_at(exp_ev, d));
        end
        tests++;
        if (count_beats(obs_ev) != 6) begin
            fails++; $display("FAIL rate beats: got %0d want 6", count_beats(obs_ev));
        end
        tests++;
        if (!has_bpm(obs_ev, 120)) begin
            fails++; $display("FAIL rate bpm120: got no 120 result, want one");
        end
        tests++;
        if (hif.Heart_Rate !== 8'd150) begin
            fails++; $display("FAIL rate Heart_Rate: got %0d want 150", hif.Heart_Rate);
        end
    endtask

    task automatic test_refractory();
        int d;
        clear_ev();
        tri_wave(6, 100, 4000, 0, 1, 2, 0, 1'b0);
        idle(30);
        obs_ev.sort(); exp_ev.sort();
        d = first_diff(obs_ev, exp_ev);
        tests++;
        if (d >= 0) begin
            fails++;
            $display("FAIL refract events: got %0d (%s) want %0d (%s)",
                     obs_ev.size(), ev_at(obs_ev, d), exp_ev.size(), ev_at(exp_ev, d));
        end
        tests++;
        if (count_beats(obs_ev) != 3) begin
            fails++; $display("FAIL refract beats: got %0d want 3", count_beats(obs_ev));
        end
        tests++;
        if (hif.Heart_Rate !== 8'd150) begin
            fails++; $display("FAIL refract Heart_Rate: got %0d want 150", hif.Heart_Rate);
        end
    endtask

    task automatic test_timeout();
        int d, k, start_iv;
        bit seen;
        clear_ev();
        start_iv = m_iv;
        k = 0; seen = 1'b0;
        while (k < 2000 && !seen) begin
            send(1000, 1);
            k++;
            if (hif.Signal_Lost === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen || k != TMO - start_iv) begin
            fails++;
            $display("FAIL timeout strobe: got lost=%b after %0d strobes want %0d",
                     seen, k, TMO - start_iv);
        end
        tests++;
        if (hif.Heart_Rate !== 8'd0) begin
            fails++; $display("FAIL timeout Heart_Rate: got %0d want 0", hif.Heart_Rate);
        end
        idle(30);
        tests++;
        if (obs_ev.size() != 0) begin
            fails++; $display("FAIL timeout events: got %0d (%s) want 0",
                              obs_ev.size(), ev_at(obs_ev, 0));
        end
        clear_ev();
        tri_wave(3, 250, 4000, 0, 1, 2, 0, 1'b0);
        idle(30);
        obs_ev.sort(); exp_ev.sort();
        d = first_diff(obs_ev, exp_ev);
        tests++;
        if (d >= 0) begin
            fails++;
            $display("FAIL recover events: got %0d (%s) want %0d (%s)",
                     obs_ev.size(), ev_at(obs_ev, d), exp_ev.size(), ev_at(exp_ev, d));
        end
        tests++;
        if (count_beats(obs_ev) != 3 || obs_ev.size() != 5) begin
            fails++;
            $display("FAIL recover counts: got beats=%0d events=%0d want 3 and 5",
                     count_beats(obs_ev), obs_ev.size());
        end
        tests++;
        if (hif.Heart_Rate !== 8'd120 || hif.Signal_Lost !== 1'b0) begin
            fails++;
            $display("FAIL recover levels: got hr=%0d lost=%b want 120 and 0",
                     hif.Heart_Rate, hif.Signal_Lost);
        end
    endtask

    task automatic test_ripple();
        int d;
        clear_ev();
        for (int i = 0; i < 600; i++)
            send(10000 + i + int'($urandom_range(0, 200)) - 100,
                 int'($urandom_range(1, 2)));
        idle(30);
        d = first_diff(obs_ev, exp_ev);
        tests++;
        if (d >= 0) begin
            fails++;
            $display("FAIL ripple events: got %0d (%s) want %0d (%s)",
                     obs_ev.size(), ev_at(obs_ev, d), exp_ev.size(), ev_at(exp_ev, d));
        end
        tests++;
        if (count_beats(obs_ev) != 0) begin
            fails++; $display("FAIL ripple beats: got %0d want 0", count_beats(obs_ev));
        end
    endtask

    task automatic test_reset_mid();
        int d, p0;
        clear_ev();
        p0 = m_pushes;
        tri_wave(4, 250, 4000, 0, 1, 1, 0, 1'b1);
        tests++;
        if (m_pushes == p0) begin
            fails++; $display("FAIL midrst setup: got no division start, want one");
        end
        idle(5);
        rst_n = 1'b0;
        #1;
        tests++;
        if (hif.Beat_Pulse !== 1'b0 || hif.HR_Valid !== 1'b0 ||
            hif.Heart_Rate !== 8'd0 || hif.Signal_Lost !== 1'b1) begin
            fails++;
            $display("FAIL midrst outputs: got bp=%b hv=%b hr=%0d lost=%b want 0 0 0 1",
                     hif.Beat_Pulse, hif.HR_Valid, hif.Heart_Rate, hif.Signal_Lost);
        end
        model_reset();
        idle(3);
        rst_n = 1'b1;
        idle(2);
        tri_wave(3, 250, 4000, 0, 1, 2, 0, 1'b0);
        idle(30);
        obs_ev.sort(); exp_ev.sort();
        d = first_diff(obs_ev, exp_ev);
        tests++;
        if (d >= 0) begin
            fails++;
            $display("FAIL midrst events: got %0d (%s) want %0d (%s)",
                     obs_ev.size(), ev_at(obs_ev, d), exp_ev.size(), ev_at(exp_ev, d));
        end
        tests++;
        if (hif.Heart_Rate !== 8'd120) begin
            fails++; $display("FAIL midrst Heart_Rate: got %0d want 120", hif.Heart_Rate);
        end
    endtask

    task automatic test_random();
        int d, per, amp, base, noise;
        for (int r = 0; r < 3; r++) begin
            clear_ev();
            per   = int'($urandom_range(160, 400));
            amp   = int'($urandom_range(600, 50000));
            base  = int'($urandom_range(60, 'hFFFFF - amp - 60));
            noise = int'($urandom_range(0, 60));
            tri_wave(4, per, amp, base, 1, 3, noise, 1'b0);
            idle(30);
            obs_ev.sort(); exp_ev.sort();
            d = first_diff(obs_ev, exp_ev);
            tests++;
            if (d >= 0) begin
                fails++;
                $display("FAIL random%0d events: got %0d (%s) want %0d (%s)", r,
                         obs_ev.size(), ev_at(obs_ev, d), exp_ev.size(), ev_at(exp_ev, d));
            end
            tests++;
            if (int'(hif.Heart_Rate) != m_hr || int'(hif.Signal_Lost) != m_lost) begin
                fails++;
                $display("FAIL random%0d levels: got hr=%0d lost=%b want %0d and %0d",
                         r, hif.Heart_Rate, hif.Signal_Lost, m_hr, m_lost);
            end
        end
    endtask

    initial begin
        m_pushes = 0;
        model_reset();
        test_reset();
        test_triangle_60();
        test_rate_change();
        test_refractory();
        test_timeout();
        test_ripple();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
